// File: rtl/demux8_pkg.sv
// rtl/demux8_pkg.sv - shared lane types, sizing constants and one-hot encoder for demux8_collector
package demux8_pkg;
    localparam int LANES         = 8;
    localparam int DEPTH_DEFAULT = 4;

    typedef logic [2:0] lane_t;

    function automatic lane_t onehot_to_index(input logic [LANES-1:0] oh);
        lane_t idx;
        idx = '0;
        for (int i = 0; i < LANES; i++) begin
            if (oh[i]) begin
                idx = lane_t'(i);
            end
        end
        return idx;
    endfunction
endpackage

// File: rtl/demux8_fifo.sv
// rtl/demux8_fifo.sv - lane-index FIFO; push while full is accepted only when a pop frees the slot
module demux8_fifo
    import demux8_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  lane_t                  din,
    output lane_t                  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW:0] FULL_CNT = CW'(DEPTH);

    lane_t         mem_q [DEPTH];
    lane_t         mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          wr_en, rd_en;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    // Head is forced to zero when empty so a same-cycle write never shows through early.
    assign dout  = empty ? lane_t'(0) : mem_q[rd_ptr_q];

    always_comb begin
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/demux8_collector.sv
// rtl/demux8_collector.sv - collects one-hot demux lane events into a FIFO; DEMUX8_COLLECT_CNT_EN adds per-lane counters
module demux8_collector
    import demux8_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] dout,
    input  logic             clr_sticky,
    input  logic             out_ready,
    output logic             out_valid,
    output lane_t            out_lane,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             err_multi,
    output logic             ovf,
    input  lane_t            cnt_sel,
    output logic [7:0]       cnt_q
);
    logic [LANES-1:0]      dout_q, dout_d;
    logic                  err_multi_q, err_multi_d;
    logic                  ovf_q, ovf_d;
    logic                  evt, evt_multi, evt_one, fifo_pop;
    lane_t                 evt_lane;
    logic [$clog2(DEPTH):0] fifo_count;

    always_comb begin
        dout_d    = dout;
        evt       = (dout != '0) && (dout != dout_q);
        // Clearing the lowest set bit leaves something behind only when two or more bits are high.
        evt_multi = evt && ((dout & (dout - 1'b1)) != '0);
        evt_one   = evt && !evt_multi;
        evt_lane  = onehot_to_index(dout);
        fifo_pop  = !fifo_empty && out_ready;

        err_multi_d = clr_sticky ? 1'b0 : err_multi_q;
        if (evt_multi) begin
            err_multi_d = 1'b1;
        end
        ovf_d = clr_sticky ? 1'b0 : ovf_q;
        if (evt_one && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q      <= '0;
            err_multi_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            err_multi_q <= err_multi_d;
            ovf_q       <= ovf_d;
        end
    end

    demux8_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt_one),
        .pop   (fifo_pop),
        .din   (evt_lane),
        .dout  (out_lane),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign err_multi = err_multi_q;
    assign ovf       = ovf_q;

`ifdef DEMUX8_COLLECT_CNT_EN
    logic [7:0] lane_cnt_q [LANES];
    logic [7:0] lane_cnt_d [LANES];

    // Dropped events still count; a clear coinciding with an event leaves a count of one.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_cnt_d[i] = clr_sticky ? 8'd0 : lane_cnt_q[i];
            if (evt_one && (evt_lane == lane_t'(i)) && (lane_cnt_d[i] != 8'hFF)) begin
                lane_cnt_d[i] = lane_cnt_d[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                lane_cnt_q[i] <= '0;
            end
        end else begin
            lane_cnt_q <= lane_cnt_d;
        end
    end

    assign cnt_q = lane_cnt_q[cnt_sel];
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_q          = 8'd0;
`endif
endmodule

// File: tb/tb_demux8_collector.sv
// tb/tb_demux8_collector.sv - scoreboard bench for demux8_collector against a queue-based reference model
module tb_demux8_collector;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dout = 8'd0;
    logic       clr_sticky = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [2:0] out_lane;
    logic       fifo_full, fifo_empty, err_multi, ovf;
    logic [2:0] cnt_sel = 3'd0;
    logic [7:0] cnt_q;

    demux8_collector #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .dout       (dout),
        .clr_sticky (clr_sticky),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_lane   (out_lane),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .err_multi  (err_multi),
        .ovf        (ovf),
        .cnt_sel    (cnt_sel),
        .cnt_q      (cnt_q)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        full;
        logic        empty;
        logic        err;
        logic        ovf;
        logic [63:0] cnts;
    } stat_t;

    int          errors = 0;
    int          checks = 0;
    logic [2:0]  sb_q[$];
    stat_t       status_q[$];

    int          m_cnt = 0;
    logic [7:0]  m_prev = 8'd0;
    logic        m_err = 1'b0;
    logic        m_ovf = 1'b0;
    int          m_lc [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_prev = 8'd0;
        m_err  = 1'b0;
        m_ovf  = 1'b0;
        for (int i = 0; i < 8; i++) m_lc[i] = 0;
        sb_q.delete();
        status_q.delete();
    endtask

    // Reference: decide what the next clock edge must do from the current inputs.
    task automatic model_step();
        bit    pop;
        bit    is_evt;
        int    ones;
        int    lane;
        stat_t s;
        pop    = (m_cnt > 0) && out_ready;
        is_evt = (dout != 8'd0) && (dout != m_prev);
        ones   = $countones(dout);
        m_prev = dout;
        if (clr_sticky) begin
            m_err = 1'b0;
            m_ovf = 1'b0;
            for (int i = 0; i < 8; i++) m_lc[i] = 0;
        end
        if (is_evt && ones > 1) m_err = 1'b1;
        if (is_evt && ones == 1) begin
            lane = $clog2(dout);
`ifdef DEMUX8_COLLECT_CNT_EN
            if (m_lc[lane] < 255) m_lc[lane]++;
`endif
            if (m_cnt < DEPTH || pop) begin
                sb_q.push_back(3'(lane));
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop) m_cnt--;
        s.v     = (m_cnt > 0);
        s.full  = (m_cnt == DEPTH);
        s.empty = (m_cnt == 0);
        s.err   = m_err;
        s.ovf   = m_ovf;
        for (int i = 0; i < 8; i++) s.cnts[i*8 +: 8] = 8'(m_lc[i]);
        status_q.push_back(s);
    endtask

    task automatic step(input logic [7:0] d, input logic rdy, input logic clr);
        @(negedge clk);
        dout       = d;
        out_ready  = rdy;
        clr_sticky = clr;
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_lane", 32'(out_lane), 32'd0);
        chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("rst_fifo_full", 32'(fifo_full), 32'd0);
        chk("rst_err_multi", 32'(err_multi), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_cnt_q", 32'(cnt_q), 32'd0);
        dout       = 8'd0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Status monitor: state just after each edge against the model's prediction.
    initial forever begin
        stat_t s;
        @(posedge clk);
        #2;
        if (!rst && status_q.size() > 0) begin
            s = status_q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(s.v));
            chk("fifo_full", 32'(fifo_full), 32'(s.full));
            chk("fifo_empty", 32'(fifo_empty), 32'(s.empty));
            chk("err_multi", 32'(err_multi), 32'(s.err));
            chk("ovf", 32'(ovf), 32'(s.ovf));
            chk("cnt_q", 32'(cnt_q), 32'(s.cnts[cnt_sel*8 +: 8]));
        end
    end

    // Data monitor: every accepted head entry must be the next expected lane.
    initial forever begin
        logic [2:0] e;
        @(negedge clk);
        #3;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pop", 32'(out_lane), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("out_lane", 32'(out_lane), 32'(e));
            end
        end
    end

    initial begin
        int         r;
        int         a;
        logic [7:0] d;
        model_reset();
        do_reset();

        // single event
        step(8'h00, 1'b1, 1'b0);
        step(8'h20, 1'b1, 1'b0);
        step(8'h20, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // hold then change
        for (int i = 0; i < 5; i++) step(8'h04, 1'b1, 1'b0);
        step(8'h08, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // overflow then drain
        for (int i = 0; i < 5; i++) step(8'(1 << i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(8'h10, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b1);

        // push and pop together while full
        for (int i = 0; i < 4; i++) step(8'(1 << i), 1'b0, 1'b0);
        step(8'h80, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(8'h80, 1'b1, 1'b0);

        // multi-hot, then clear
        step(8'h81, 1'b1, 1'b0);
        step(8'h81, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                d = 8'h00;
            end else if (r < 4) begin
                d = dout;
            end else if (r < 9) begin
                d = 8'd1 << $urandom_range(0, 7);
            end else begin
                a = $urandom_range(0, 7);
                d = (8'd1 << a) | (8'd1 << ((a + $urandom_range(1, 7)) % 8));
            end
            cnt_sel = 3'($urandom_range(0, 7));
            step(d, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // reset with entries queued
        step(8'h00, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h02, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        do_reset();

        // counter saturation on lane 2
        cnt_sel = 3'd2;
        for (int i = 0; i < 300; i++) begin
            step(8'h04, 1'b1, 1'b0);
            step(8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < DEPTH + 2; i++) step(8'h00, 1'b1, 1'b0);
        @(negedge clk);
`ifdef DEMUX8_COLLECT_CNT_EN
        chk("cnt_sat_lane2", 32'(cnt_q), 32'd255);
`else
        chk("cnt_tied_zero", 32'(cnt_q), 32'd0);
`endif
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
